// File: rtl/line_buffer_taps_if.sv
// Pixel push / tap bundle for line_buffer_taps.
// master: pixel source (en, in, line_len, flush); slave: the line buffer (tap outputs).
interface line_buffer_taps_if #(
   parameter int DATA_WIDTH = 12,
   parameter int MAX_LINE   = 640,
   parameter int NUM_TAPS   = 2
);
   localparam int LW = $clog2(MAX_LINE + 1);
   localparam int AW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;

   logic                           en;
   logic [DATA_WIDTH-1:0]          in;
   logic [LW-1:0]                  line_len;
   logic                           flush;
   logic [DATA_WIDTH-1:0]          tap0;
   logic [NUM_TAPS*DATA_WIDTH-1:0] taps;
   logic [NUM_TAPS-1:0]            tap_valid;
   logic [2:0]                     line_cnt;
   logic [AW-1:0]                  col;

   modport master (
      output en, in, line_len, flush,
      input  tap0, taps, tap_valid, line_cnt, col
   );

   modport slave (
      input  en, in, line_len, flush,
      output tap0, taps, tap_valid, line_cnt, col
   );
endinterface

// File: rtl/line_buffer_taps.sv
// Multi-line delay buffer: taps k*L pushes back from the last accepted pixel.
// Ports: clk, rst (sync, active-high), bus (slave: en/in/line_len/flush in, tap0/taps/tap_valid/line_cnt/col out).
module line_buffer_taps #(
   parameter int DATA_WIDTH = 12,
   parameter int MAX_LINE   = 640,
   parameter int NUM_TAPS   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   line_buffer_taps_if.slave    bus
);
   localparam int LW = $clog2(MAX_LINE + 1);
   localparam int AW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
   localparam int TW = NUM_TAPS * DATA_WIDTH;

   logic [DATA_WIDTH-1:0] mem [NUM_TAPS][MAX_LINE];
   logic [DATA_WIDTH-1:0] rd  [NUM_TAPS];

   logic [LW-1:0]         lq_q, lq_d;
   logic [AW-1:0]         ptr_q, ptr_d;
   logic [AW-1:0]         col_q, col_d;
   logic [2:0]            line_cnt_q, line_cnt_d;
   logic                  seen_q, seen_d;
   logic [DATA_WIDTH-1:0] tap0_q, tap0_d;
   logic [TW-1:0]         taps_q, taps_d;
   logic [NUM_TAPS-1:0]   valid_q, valid_d;
   logic                  push;

   assign push = bus.en && !rst && !bus.flush;

   // Store k holds the pixel k+1 lines back at each column position.
   always_comb begin
      for (int k = 0; k < NUM_TAPS; k++) begin
         rd[k] = mem[k][ptr_q];
      end
   end

   always_comb begin
      lq_d       = lq_q;
      ptr_d      = ptr_q;
      col_d      = col_q;
      line_cnt_d = line_cnt_q;
      seen_d     = seen_q;
      tap0_d     = tap0_q;
      taps_d     = taps_q;
      valid_d    = valid_q;
      if (rst || bus.flush) begin
         if (bus.line_len != '0 && bus.line_len <= LW'(MAX_LINE)) begin
            lq_d = bus.line_len;
         end else begin
            lq_d = LW'(MAX_LINE);
         end
         ptr_d      = '0;
         col_d      = '0;
         line_cnt_d = '0;
         seen_d     = 1'b0;
         tap0_d     = '0;
         taps_d     = '0;
         valid_d    = '0;
      end else if (bus.en) begin
         tap0_d = bus.in;
         col_d  = ptr_q;
         seen_d = 1'b1;
         if (ptr_q == AW'(lq_q - LW'(1))) begin
            ptr_d = '0;
         end else begin
            ptr_d = ptr_q + AW'(1);
         end
         // Column 0 after the very first push closes a line.
         if (seen_q && ptr_q == '0 && line_cnt_q < 3'(NUM_TAPS)) begin
            line_cnt_d = line_cnt_q + 3'd1;
         end
         for (int k = 0; k < NUM_TAPS; k++) begin
            valid_d[k] = (line_cnt_d > 3'(k));
            taps_d[k*DATA_WIDTH +: DATA_WIDTH] =
               valid_d[k] ? rd[k] : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lq_q       <= lq_d;
         ptr_q      <= '0;
         col_q      <= '0;
         line_cnt_q <= '0;
         seen_q     <= 1'b0;
         tap0_q     <= '0;
         taps_q     <= '0;
         valid_q    <= '0;
      end else begin
         lq_q       <= lq_d;
         ptr_q      <= ptr_d;
         col_q      <= col_d;
         line_cnt_q <= line_cnt_d;
         seen_q     <= seen_d;
         tap0_q     <= tap0_d;
         taps_q     <= taps_d;
         valid_q    <= valid_d;
      end
   end

   // Stores cascade: each shifts its old column value down one line.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[0][ptr_q] <= bus.in;
         for (int k = 1; k < NUM_TAPS; k++) begin
            mem[k][ptr_q] <= rd[k-1];
         end
      end
   end

   assign bus.tap0      = tap0_q;
   assign bus.taps      = taps_q;
   assign bus.tap_valid = valid_q;
   assign bus.line_cnt  = line_cnt_q;
   assign bus.col       = col_q;
endmodule

// File: tb/tb_line_buffer_taps.sv
// Bench for line_buffer_taps: pixel-history model plus directed literal checks.
// Drives the interface master side; DUT sits on the slave side.
module tb_line_buffer_taps;
   localparam int DW = 12;
   localparam int ML = 20;
   localparam int NT = 2;
   localparam int LW = $clog2(ML + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   line_buffer_taps_if #(.DATA_WIDTH(DW), .MAX_LINE(ML), .NUM_TAPS(NT)) bus();

   line_buffer_taps #(.DATA_WIDTH(DW), .MAX_LINE(ML), .NUM_TAPS(NT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int hist[$];
   int m_lq = ML;
   int len_in = 4;
   bit chk_on = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;

   function automatic int latch_len(int len);
      return (len >= 1 && len <= ML) ? len : ML;
   endfunction

   function automatic bit exp_valid(int k);
      int n = hist.size();
      return (n > 0) && (n - 1 >= k * m_lq);
   endfunction

   function automatic int exp_tap(int k);
      int n = hist.size();
      if (!exp_valid(k)) return 0;
      return hist[n - 1 - k * m_lq];
   endfunction

   function automatic int exp_col();
      int n = hist.size();
      return (n == 0) ? 0 : (n - 1) % m_lq;
   endfunction

   function automatic int exp_cnt();
      int n = hist.size();
      int c;
      if (n == 0) return 0;
      c = (n - 1) / m_lq;
      return (c > NT) ? NT : c;
   endfunction

   function automatic int dut_tap(int k);
      return int'(bus.taps[(k-1)*DW +: DW]);
   endfunction

   task automatic cmp(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         cmp("m_tap0", int'(bus.tap0), hist.size() ? hist[$] : 0);
         for (int k = 1; k <= NT; k++) begin
            cmp($sformatf("m_tap%0d", k), dut_tap(k), exp_tap(k));
            cmp($sformatf("m_valid%0d", k), int'(bus.tap_valid[k-1]),
                int'(exp_valid(k)));
         end
         cmp("m_line_cnt", int'(bus.line_cnt), exp_cnt());
         cmp("m_col", int'(bus.col), exp_col());
      end
   end

   task automatic cyc(bit r, bit f, bit e, int d);
      rst          = r;
      bus.flush    = f;
      bus.en       = e;
      bus.in       = DW'(d);
      bus.line_len = LW'(len_in);
      @(posedge clk);
      if (r || f) begin
         hist.delete();
         m_lq = latch_len(len_in);
      end else if (e) begin
         hist.push_back(d & ((1 << DW) - 1));
      end
      chk_on = 1'b1;
      @(negedge clk);
   endtask

   task automatic push(int v);
      cyc(1'b0, 1'b0, 1'b1, v);
   endtask

   task automatic push_range(int a, int b);
      for (int v = a; v <= b; v++) push(v);
   endtask

   initial begin
      rst = 1'b1;
      bus.flush = 1'b0;
      bus.en = 1'b0;
      bus.in = '0;
      bus.line_len = LW'(4);
      @(negedge clk);

      // Continuous fill, L=4
      len_in = 4;
      cyc(1'b1, 1'b0, 1'b0, 0);
      cmp("rst_tap0", int'(bus.tap0), 0);
      cmp("rst_valid", int'(bus.tap_valid), 0);
      push_range(1, 5);
      cmp("p5_tap1", dut_tap(1), 1);
      cmp("p5_valid", int'(bus.tap_valid), 1);
      push_range(6, 9);
      cmp("p9_tap2", dut_tap(2), 1);
      cmp("p9_valid", int'(bus.tap_valid), 3);
      push_range(10, 12);
      cmp("p12_tap0", int'(bus.tap0), 12);
      cmp("p12_tap1", dut_tap(1), 8);
      cmp("p12_tap2", dut_tap(2), 4);
      cmp("p12_cnt", int'(bus.line_cnt), 2);

      // Gap in en
      cyc(1'b1, 1'b0, 1'b0, 0);
      push_range(1, 3);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 77);
         cmp("gap_tap0", int'(bus.tap0), 3);
         cmp("gap_col", int'(bus.col), 2);
      end
      push_range(4, 6);
      cmp("gap_tap1", dut_tap(1), 2);
      cmp("gap_col6", int'(bus.col), 1);

      // Flush with concurrent push
      cyc(1'b1, 1'b0, 1'b0, 0);
      push_range(1, 6);
      cyc(1'b0, 1'b1, 1'b1, 99);
      cmp("fl_tap0", int'(bus.tap0), 0);
      cmp("fl_taps", int'(bus.taps), 0);
      cmp("fl_valid", int'(bus.tap_valid), 0);
      cmp("fl_col", int'(bus.col), 0);
      push_range(1, 4);
      cmp("fl4_valid", int'(bus.tap_valid), 0);
      cmp("fl4_col", int'(bus.col), 3);

      // Out-of-range lengths fall back to MAX_LINE
      for (int t = 0; t < 2; t++) begin
         len_in = (t == 0) ? 0 : ML + 1;
         cyc(1'b1, 1'b0, 1'b0, 0);
         push_range(1, ML);
         cmp("ml_valid", int'(bus.tap_valid), 0);
         cmp("ml_col", int'(bus.col), ML - 1);
         push(ML + 1);
         cmp("ml_tap1", dut_tap(1), 1);
         cmp("ml_valid1", int'(bus.tap_valid), 1);
      end

      // line_len ignored until flush
      len_in = 4;
      cyc(1'b1, 1'b0, 1'b0, 0);
      push_range(1, 3);
      len_in = 6;
      push_range(4, 5);
      cmp("len_tap1", dut_tap(1), 1);
      cyc(1'b0, 1'b1, 1'b0, 0);
      push_range(1, 6);
      cmp("len6_valid", int'(bus.tap_valid), 0);
      push(7);
      cmp("len7_tap1", dut_tap(1), 1);

      // Reset mid-stream
      len_in = 4;
      cyc(1'b1, 1'b0, 1'b0, 0);
      push_range(1, 7);
      cyc(1'b1, 1'b0, 1'b1, 55);
      cmp("mr_tap0", int'(bus.tap0), 0);
      cmp("mr_valid", int'(bus.tap_valid), 0);
      cmp("mr_cnt", int'(bus.line_cnt), 0);
      push_range(1, 4);
      cmp("mr4_valid", int'(bus.tap_valid), 0);
      push(5);
      cmp("mr5_tap1", dut_tap(1), 1);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         bit r, f, e;
         r = ($urandom_range(0, 299) == 0);
         f = ($urandom_range(0, 99) == 0);
         e = ($urandom_range(0, 3) != 0);
         len_in = $urandom_range(0, ML + 1);
         cyc(r, f, e, int'($urandom_range(0, (1 << DW) - 1)));
      end

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/line_buffer_taps.md
LINE_BUFFER_TAPS -- requirements
Module: line_buffer_taps

Interface
REQ-001 Parameter DATA_WIDTH, default 12, bit width of each pixel.
REQ-002 Parameter MAX_LINE, default 640, maximum line length in pixels (depth of each line store).
REQ-003 Parameter NUM_TAPS, default 2, number of delayed-line taps (1..4).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  push strobe; one pixel accepted per cycle with en=1.
REQ-007 in  input  DATA_WIDTH  pixel pushed when en=1.
REQ-008 line_len  input  clog2(MAX_LINE+1)  runtime line length L; sampled only at reset/flush.
REQ-009 flush  input  1  synchronous restart of line tracking.
REQ-010 tap0  output  DATA_WIDTH  registered copy of last accepted pixel.
REQ-011 taps  output  NUM_TAPS*DATA_WIDTH  slice k-1 = tap k, pixel pushed k*L pushes before the last accepted one.
REQ-012 tap_valid  output  NUM_TAPS  bit k-1 high when tap k holds real data.
REQ-013 line_cnt  output  3  completed lines since reset/flush, saturating at NUM_TAPS.
REQ-014 col  output  clog2(MAX_LINE)  column index of last accepted pixel, 0..L-1.

Function
REQ-015 Latched length Lq = line_len when 1<=line_len<=MAX_LINE, else MAX_LINE; captured on rst or flush cycle; line_len changes otherwise ignored.
REQ-016 Storage: NUM_TAPS circular line stores of MAX_LINE entries, one shared write/read pointer wrapping from Lq-1 to 0; no per-entry reset required.
REQ-017 On accepted push n (n=0 first after reset/flush): next cycle tap0=in(n), tap k=in(n-k*Lq) if n>=k*Lq.
REQ-018 Latency: one cycle from en edge to updated tap0/taps/tap_valid/col/line_cnt.
REQ-019 tap_valid[k-1] rises on the edge accepting push n=k*Lq and stays high until rst/flush.
REQ-020 Any tap with tap_valid bit low SHALL output 0.
REQ-021 col = n mod Lq; wraps Lq-1 -> 0.
REQ-022 line_cnt increments on the edge accepting a push with col wrapping to 0 (pushes Lq, 2Lq, ...), saturates at NUM_TAPS.
REQ-023 en=0: all outputs and storage hold.
REQ-024 flush=1: pointer, col, line_cnt, tap_valid, tap0, taps cleared to 0 next cycle; Lq relatched; store contents may remain.
REQ-025 flush and en same cycle: flush wins, pixel discarded.
REQ-026 Continuous en=1 at full rate SHALL sustain one pixel per cycle indefinitely without stalls.

Reset
REQ-027 rst=1 at rising edge: tap0=0, taps=0, tap_valid=0, line_cnt=0, col=0, pointer=0, Lq relatched.
REQ-028 rst has priority over flush and en; reset mid-line discards partial line; first push after rst is n=0.

Verification
REQ-029 NUM_TAPS=2, line_len=4, push 1..12 continuously -> after push 5 (n=4) tap1=1, tap_valid=01; after push 9 tap2=1, tap_valid=11; after push 12 tap0=12, tap1=8, tap2=4, line_cnt=2.
REQ-030 line_len=4, push 1..6 with en dropped for 3 cycles after push 3 -> outputs hold during gap; after push 6 tap1=2, col=1.
REQ-031 line_len=4, push 1..6, flush asserted with en=1 and in=99 -> next cycle all outputs 0, 99 not stored; push 1..4 again -> tap_valid=00, col=3.
REQ-032 line_len=0 and line_len=MAX_LINE+1 at reset -> Lq=MAX_LINE; tap1 first valid on push MAX_LINE+1 with value of push 1.
REQ-033 line_len changed 4->6 mid-stream without flush -> behaviour continues with Lq=4; after flush, Lq=6 and tap1 valid on 7th push.
REQ-034 rst asserted after push 7 at line_len=4 -> next cycle all outputs 0; subsequent pushes 1..5 -> tap1=1 only after push 5.
